// File: rtl/video_timing_receiver.sv
// Video timing receiver: registers the incoming sync/blank strobes, measures
// line and frame lengths, tracks the active-area pixel position and decides
// when the incoming timing is stable enough to be trusted (lock).
module video_timing_receiver #(
    parameter int SIZE        = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            h_sync,
    input  logic            v_sync,
    input  logic            h_blank,
    input  logic            v_blank,
    output logic            de,
    output logic [SIZE-1:0] x,
    output logic [SIZE-1:0] y,
    output logic            line_start,
    output logic            frame_start,
    output logic [SIZE-1:0] h_total,
    output logic [SIZE-1:0] v_total,
    output logic            locked,
    output logic            err
);

    localparam logic [SIZE-1:0] CNT_ZERO    = {SIZE{1'b0}};
    localparam logic [SIZE-1:0] CNT_ONE     = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [SIZE-1:0] CNT_MAX     = {SIZE{1'b1}};
    localparam logic [3:0]      LOCK_TARGET = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    logic            hs_s1_r, vs_s1_r, hb_s1_r, vb_s1_r;
    logic            hs_prev_r, vs_prev_r, hb_prev_r;
    logic [SIZE-1:0] h_cnt_r, v_cnt_r, x_cnt_r, y_cnt_r;
    logic            armed_r;
    logic            h_chg_seen_r;
    logic [3:0]      match_r;
    lock_state_t     state_r;

    logic            h_rise_s, v_rise_s, hb_rise_s;
    logic [SIZE-1:0] h_len_s, v_len_s;
    logic            h_sat_s, v_sat_s, h_chg_s, v_chg_s, frame_h_chg_s;
    lock_state_t     state_next_s;
    logic [3:0]      match_next_s;
    logic            err_s, lock_next_s, de_next_s;

    assign h_rise_s  = hs_s1_r & ~hs_prev_r;
    assign v_rise_s  = vs_s1_r & ~vs_prev_r;
    assign hb_rise_s = hb_s1_r & ~hb_prev_r;

    // Line length ends at this rise, so it is the count plus the rise clock itself.
    assign h_len_s = (h_cnt_r == CNT_MAX) ? CNT_MAX : (h_cnt_r + CNT_ONE);
    // Frame length includes an h_sync rise landing in the same cycle as v_sync.
    assign v_len_s = (h_rise_s && (v_cnt_r != CNT_MAX)) ? (v_cnt_r + CNT_ONE) : v_cnt_r;

    // Saturation is flagged only on the step into the maximum, so it pulses once.
    assign h_sat_s = (h_cnt_r == (CNT_MAX - CNT_ONE)) && !h_rise_s;
    assign v_sat_s = (v_cnt_r == (CNT_MAX - CNT_ONE)) && h_rise_s && !v_rise_s;

    assign h_chg_s       = h_rise_s && armed_r && (h_len_s != h_total);
    assign v_chg_s       = v_rise_s && (v_len_s != v_total);
    assign frame_h_chg_s = h_chg_seen_r | h_chg_s;

    // Lock decision: next state, match counter and error pulse.
    always_comb begin
        state_next_s = state_r;
        match_next_s = match_r;
        err_s        = 1'b0;
        if (h_sat_s || v_sat_s) begin
            state_next_s = SEARCH;
            match_next_s = 4'd0;
            err_s        = 1'b1;
        end else begin
            case (state_r)
                SEARCH: begin
                    if (v_rise_s && armed_r) begin
                        state_next_s = TRACK;
                        match_next_s = 4'd0;
                    end else begin
                        state_next_s = SEARCH;
                    end
                end
                TRACK: begin
                    if (v_rise_s) begin
                        if (!v_chg_s && !frame_h_chg_s) begin
                            match_next_s = match_r + 4'd1;
                            if ((match_r + 4'd1) == LOCK_TARGET) begin
                                state_next_s = LOCKED;
                            end else begin
                                state_next_s = TRACK;
                            end
                        end else begin
                            match_next_s = 4'd0;
                        end
                    end else begin
                        state_next_s = TRACK;
                    end
                end
                LOCKED: begin
                    if (h_chg_s || v_chg_s) begin
                        state_next_s = SEARCH;
                        match_next_s = 4'd0;
                        err_s        = 1'b1;
                    end else begin
                        state_next_s = LOCKED;
                    end
                end
                default: begin
                    state_next_s = SEARCH;
                    match_next_s = 4'd0;
                end
            endcase
        end
    end

    assign lock_next_s = (state_next_s == LOCKED);
    assign de_next_s   = ~hb_s1_r & ~vb_s1_r & lock_next_s;

    // Input stage, edge-history registers and lock state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_s1_r   <= 1'b0;
            vs_s1_r   <= 1'b0;
            hb_s1_r   <= 1'b0;
            vb_s1_r   <= 1'b0;
            hs_prev_r <= 1'b0;
            vs_prev_r <= 1'b0;
            hb_prev_r <= 1'b0;
            state_r   <= SEARCH;
            match_r   <= 4'd0;
        end else begin
            hs_s1_r   <= h_sync;
            vs_s1_r   <= v_sync;
            hb_s1_r   <= h_blank;
            vb_s1_r   <= v_blank;
            hs_prev_r <= hs_s1_r;
            vs_prev_r <= vs_s1_r;
            hb_prev_r <= hb_s1_r;
            state_r   <= state_next_s;
            match_r   <= match_next_s;
        end
    end

    // Line/frame/pixel counters and measurement bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r      <= CNT_ZERO;
            v_cnt_r      <= CNT_ZERO;
            x_cnt_r      <= CNT_ZERO;
            y_cnt_r      <= CNT_ZERO;
            armed_r      <= 1'b0;
            h_chg_seen_r <= 1'b0;
        end else begin
            if (h_rise_s) begin
                h_cnt_r <= CNT_ZERO;
                armed_r <= 1'b1;
            end else if (h_cnt_r != CNT_MAX) begin
                h_cnt_r <= h_cnt_r + CNT_ONE;
            end
            v_cnt_r <= v_rise_s ? CNT_ZERO : v_len_s;
            if (v_rise_s) begin
                h_chg_seen_r <= 1'b0;
            end else if (h_chg_s) begin
                h_chg_seen_r <= 1'b1;
            end
            if (hb_s1_r) begin
                x_cnt_r <= CNT_ZERO;
            end else if (x_cnt_r != CNT_MAX) begin
                x_cnt_r <= x_cnt_r + CNT_ONE;
            end
            if (vb_s1_r) begin
                y_cnt_r <= CNT_ZERO;
            end else if (hb_rise_s && (y_cnt_r != CNT_MAX)) begin
                y_cnt_r <= y_cnt_r + CNT_ONE;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de          <= 1'b0;
            x           <= CNT_ZERO;
            y           <= CNT_ZERO;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            h_total     <= CNT_ZERO;
            v_total     <= CNT_ZERO;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            de          <= de_next_s;
            x           <= de_next_s ? x_cnt_r : CNT_ZERO;
            y           <= de_next_s ? y_cnt_r : CNT_ZERO;
            line_start  <= h_rise_s;
            frame_start <= v_rise_s;
            if (h_rise_s && armed_r) begin
                h_total <= h_len_s;
            end
            if (v_rise_s) begin
                v_total <= v_len_s;
            end
            locked      <= lock_next_s;
            err         <= err_s;
        end
    end

endmodule

// File: tb/tb_video_timing_receiver.sv
// Bench for video_timing_receiver: a small scaled-down raster (40x20 clocks,
// 24x12 active) drives the DUT; a timestamp-based reference model predicts
// every output each cycle, and phase checks pin lock timing and counts.
module tb_video_timing_receiver;

    localparam int HT = 40, HA = 24, HS0 = 28, HS1 = 33;
    localparam int VT = 20, VA = 12, VS0 = 13, VS1 = 15;
    localparam int LF = 2, MAXV = 1023;
    localparam int ST_SEARCH = 0, ST_TRACK = 1, ST_LOCKED = 2;

    logic       clk = 1'b0, rst = 1'b1;
    logic       h_sync = 1'b0, v_sync = 1'b0, h_blank = 1'b0, v_blank = 1'b0;
    logic       de, line_start, frame_start, locked, err;
    logic [9:0] x, y, h_total, v_total;

    video_timing_receiver #(.SIZE(10), .LOCK_FRAMES(LF)) dut (
        .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
        .h_blank(h_blank), .v_blank(v_blank), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start),
        .h_total(h_total), .v_total(v_total), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_t, m_L, m_lh, m_htot, m_vtot, m_vc, m_st, m_match, m_yc;
    bit m_armed, m_hflag;
    bit s1_hs, s1_vs, s1_hb, s1_vb, p_hs, p_vs, p_hb;
    int e_x, e_y, e_htot, e_vtot;
    bit e_de, e_ls, e_fs, e_locked, e_err;

    task automatic model_reset();
        m_t = 0; m_L = -1; m_lh = -1; m_htot = 0; m_vtot = 0; m_vc = 0;
        m_st = ST_SEARCH; m_match = 0; m_yc = 0; m_armed = 0; m_hflag = 0;
        {s1_hs, s1_vs, s1_hb, s1_vb, p_hs, p_vs, p_hb} = '0;
        e_x = 0; e_y = 0; e_htot = 0; e_vtot = 0;
        {e_de, e_ls, e_fs, e_locked, e_err} = '0;
    endtask

    task automatic model_step();
        bit hr, vr, hbr, hsat, vsat, hchg, vchg, fh, er;
        int newh, newv, xc, nst;
        hr   = s1_hs && !p_hs;
        vr   = s1_vs && !p_vs;
        hbr  = s1_hb && !p_hb;
        // clocks since the last h_sync rise (or since reset)
        hsat = ((m_t - m_L - 1) == MAXV - 1) && !hr;
        vsat = (m_vc == MAXV - 1) && hr && !vr;
        newh = (m_t - m_L > MAXV) ? MAXV : (m_t - m_L);
        newv = (m_vc + int'(hr) > MAXV) ? MAXV : (m_vc + int'(hr));
        hchg = hr && m_armed && (newh != m_htot);
        vchg = vr && (newv != m_vtot);
        fh   = m_hflag || hchg;
        nst  = m_st;
        er   = 0;
        if (hsat || vsat) begin
            nst = ST_SEARCH; er = 1;
        end else if (m_st == ST_SEARCH) begin
            if (vr && m_armed) begin nst = ST_TRACK; m_match = 0; end
        end else if (m_st == ST_TRACK) begin
            if (vr) begin
                if (!vchg && !fh) begin
                    m_match++;
                    if (m_match >= LF) nst = ST_LOCKED;
                end else m_match = 0;
            end
        end else if (hchg || vchg) begin
            nst = ST_SEARCH; er = 1;
        end
        xc = (m_t - m_lh - 1 > MAXV) ? MAXV : (m_t - m_lh - 1);
        e_locked = (nst == ST_LOCKED);
        e_de     = !s1_hb && !s1_vb && e_locked;
        e_x      = e_de ? xc : 0;
        e_y      = e_de ? m_yc : 0;
        e_ls     = hr;
        e_fs     = vr;
        e_err    = er;
        if (hr) begin
            if (m_armed) m_htot = newh;
            m_armed = 1; m_L = m_t;
        end
        if (vr) begin m_vtot = newv; m_vc = 0; end
        else if (hr) m_vc++;
        if (vr) m_hflag = 0;
        else if (hchg) m_hflag = 1;
        if (s1_hb) m_lh = m_t;
        if (s1_vb) m_yc = 0;
        else if (hbr && m_yc < MAXV) m_yc++;
        e_htot = m_htot; e_vtot = m_vtot; m_st = nst;
        {p_hs, p_vs, p_hb} = {s1_hs, s1_vs, s1_hb};
        {s1_hs, s1_vs, s1_hb, s1_vb} = {h_sync, v_sync, h_blank, v_blank};
        m_t++;
    endtask

    // observation totals, written only by the compare process
    int fs_total = 0, ls_total = 0, err_total = 0, de_total = 0, both_total = 0;
    int lock_fs = -1, err_fs = -1;
    bit prev_locked = 0;

    // compare process: advance model at each edge, check outputs 1 time unit later
    initial begin : compare_proc
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
            #1;
            check("de", de, e_de);
            check("x", x, e_x);
            check("y", y, e_y);
            check("line_start", line_start, e_ls);
            check("frame_start", frame_start, e_fs);
            check("h_total", h_total, e_htot);
            check("v_total", v_total, e_vtot);
            check("locked", locked, e_locked);
            check("err", err, e_err);
            if (frame_start) fs_total++;
            if (line_start) ls_total++;
            if (line_start && frame_start) both_total++;
            if (de) de_total++;
            if (err) begin err_total++; err_fs = fs_total; end
            if (locked && !prev_locked) lock_fs = fs_total;
            prev_locked = locked;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    int pos_l = 0, pos_c = 0, short_line = -1;
    bit vmode = 0;

    task automatic tick();
        int lin, len;
        h_sync  = (pos_c >= HS0) && (pos_c <= HS1);
        h_blank = (pos_c >= HA);
        v_blank = (pos_l >= VA);
        if (vmode) begin
            lin    = pos_l * HT + pos_c;
            v_sync = (lin >= VA * HT + HS0) && (lin < (VS1 + 1) * HT + HS0);
        end else begin
            v_sync = (pos_l >= VS0) && (pos_l <= VS1);
        end
        len = (pos_l == short_line) ? HT - 1 : HT;
        pos_c++;
        if (pos_c == len) begin
            pos_c = 0;
            pos_l++;
            if (pos_l == VT) pos_l = 0;
        end
        @(negedge clk);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            do tick(); while (!(pos_l == 0 && pos_c == 0));
        end
    endtask

    int fs_base, de_base, ls_base, err_base, both_base;

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("rst_locked", locked, 0);
        check("rst_de", de, 0);
        check("rst_h_total", h_total, 0);
        check("rst_v_total", v_total, 0);

        // acquire lock from power-up
        rst = 1'b0;
        fs_base = fs_total;
        run_frames(6);
        check("lock_after_frames", lock_fs - fs_base, LF + 2);
        check("meas_h_total", h_total, HT);
        check("meas_v_total", v_total, VT);
        check("locked_steady", locked, 1);

        // one clean locked frame
        de_base = de_total; fs_base = fs_total; ls_base = ls_total; err_base = err_total;
        run_frames(1);
        check("frame_de_count", de_total - de_base, HA * VA);
        check("frame_fs_count", fs_total - fs_base, 1);
        check("frame_ls_count", ls_total - ls_base, VT);
        check("frame_no_err", err_total - err_base, 0);

        // one short line while locked, then re-acquire
        err_base = err_total;
        short_line = 5;
        run_frames(1);
        short_line = -1;
        check("short_err_once", err_total - err_base, 1);
        check("short_unlocked", locked, 0);
        run_frames(4);
        check("relock_frames", lock_fs - err_fs, LF + 1);
        check("relocked", locked, 1);

        // reset mid-frame while locked
        repeat (5 * HT + 2) tick();
        rst = 1'b1;
        #1;
        check("midrst_locked", locked, 0);
        check("midrst_de", de, 0);
        check("midrst_h_total", h_total, 0);
        check("midrst_v_total", v_total, 0);
        check("midrst_x", x, 0);
        tick();
        rst = 1'b0;
        fs_base = fs_total;
        run_frames(5);
        check("midrst_relock_frames", lock_fs - fs_base, LF + 2);

        // h_sync and v_sync rising together
        rst = 1'b1;
        pos_l = 0; pos_c = 0; vmode = 1;
        tick();
        rst = 1'b0;
        fs_base = fs_total; both_base = both_total;
        run_frames(6);
        check("coinc_both_pulses", both_total - both_base, 6);
        check("coinc_v_total", v_total, VT);
        check("coinc_lock_frames", lock_fs - fs_base, LF + 2);
        check("coinc_locked", locked, 1);

        // h_sync held low long enough to saturate the line counter
        err_base = err_total;
        for (int i = 0; i < 1100; i++) begin
            h_sync = 1'b0; v_sync = 1'b0; h_blank = 1'b1; v_blank = 1'b1;
            @(negedge clk);
        end
        check("sat_err_once", err_total - err_base, 1);
        check("sat_unlocked", locked, 0);
        check("sat_de", de, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_receiver.md
VIDEO_TIMING_RECEIVER -- requirements
Module: video_timing_receiver

Interface
REQ-001 Parameter SIZE, default 10: width of all counters, coordinates and measured totals.
REQ-002 Parameter LOCK_FRAMES, default 2: consecutive matching frames required to enter LOCKED (range 1..15).
REQ-003 clk  input  1  pixel clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 h_sync, v_sync, h_blank, v_blank  input  1 each  active-high timing strobes, synchronous to clk.
REQ-006 de  output  1  active pixel; asserted only while locked.
REQ-007 x, y  output  SIZE each  active-area pixel column and row for the current de cycle.
REQ-008 line_start, frame_start  output  1 each  single-cycle pulses on the detected h_sync and v_sync rising edges.
REQ-009 h_total, v_total  output  SIZE each  last measured line length in clocks and frame length in lines.
REQ-010 locked  output  1  level; timing stable.
REQ-011 err  output  1  single-cycle pulse on a timing mismatch or counter saturation.

Function
REQ-012 All four inputs SHALL be registered once (stage 1); edges SHALL be detected from stage 1 versus its previous value; all outputs SHALL be registered, giving 2 cycles total latency from input to output.
REQ-013 h_cnt: SHALL clear to 0 on an h_sync rise, otherwise increment, saturating at 2^SIZE-1.
REQ-014 On an h_sync rise, h_total SHALL load h_cnt+1 and line_start SHALL pulse; the first rise after reset SHALL only arm measurement (h_total unchanged).
REQ-015 v_cnt: SHALL increment on each h_sync rise; on a v_sync rise, v_total SHALL load v_cnt including a same-cycle h_sync rise, v_cnt SHALL clear to 0, and frame_start SHALL pulse.
REQ-016 x: SHALL hold 0 while stage-1 h_blank=1 and otherwise increment per cycle, so the first active pixel of a line reports x=0.
REQ-017 y: SHALL hold 0 while stage-1 v_blank=1 and SHALL increment on each h_blank rising edge while v_blank=0, so the first active line reports y=0.
REQ-018 de SHALL equal (stage-1 h_blank=0 AND v_blank=0 AND locked).
REQ-019 Lock FSM states SHALL be SEARCH, TRACK and LOCKED.
REQ-020 SEARCH: the first v_sync rise after measurement is armed SHALL move the FSM to TRACK, with match_cnt=0.
REQ-021 TRACK: at each v_sync rise, if v_total is unchanged from the previous frame and no line in the frame changed h_total, match_cnt SHALL increment, otherwise it SHALL clear.
REQ-022 TRACK: when match_cnt reaches LOCK_FRAMES, the FSM SHALL move to LOCKED and locked SHALL assert.
REQ-023 LOCKED: any h_total change at an h_sync rise or v_total change at a v_sync rise SHALL pulse err, deassert locked on the next cycle and move the FSM to SEARCH.
REQ-024 A saturation of h_cnt or v_cnt SHALL pulse err once and force the FSM to SEARCH from any state.
REQ-025 Simultaneous h_sync and v_sync rises SHALL both be processed in the same cycle (line_start and frame_start both pulse).
REQ-026 Mismatches detected in SEARCH or TRACK SHALL NOT pulse err.

Reset
REQ-027 While rst=1, FSM=SEARCH, all counters=0, h_total=v_total=0, and de, locked, line_start, frame_start, err, x and y SHALL all be 0.
REQ-028 Asserting rst mid-frame SHALL take effect immediately (asynchronous); after release, the block SHALL re-arm and re-acquire from SEARCH as after power-up.

Verification
REQ-029 Drive a 528x628 stream (active 400x600, h_sync over clocks 420..483 of each line, v_sync over lines 601..604) -> h_total=528, v_total=628; locked rises after the v_sync rise that ends frame 1+LOCK_FRAMES.
REQ-030 Locked stream -> per line, exactly 400 de cycles with x=0..399 for each of 600 lines y=0..599; de 2 cycles after the matching input; one frame_start per 628 lines.
REQ-031 Locked stream with one line shortened to 527 clocks -> err pulses once at that line's closing h_sync rise, locked falls, then relocks after LOCK_FRAMES+1 clean frames.
REQ-032 Hold h_sync low for 1100 clocks -> h_cnt saturates at 1023, a single err pulse occurs and FSM=SEARCH; de stays 0.
REQ-033 Stream where h_sync and v_sync rise in the same cycle -> line_start and frame_start pulse in the same cycle, v_total counts that line, and lock is still achieved.
REQ-034 Assert rst for 1 cycle mid-frame while locked -> all outputs read 0 within the reset cycle, then lock is re-achieved after identical frame count as in REQ-029.
